flex_stp_word_rx: RTL and testbench
===================================

Name: flex_stp_word_rx

Overview:
Parametrised serial-to-parallel receiver: shifts serial bits into a NUM_BITS register, counts bits per word, and pushes each completed word into a DEPTH-entry output FIFO with a valid/ready interface. Adds word framing, buffering, back-pressure and overrun detection over a plain shift register. Sits between a bit-level front end (sampler/timer) and a word-level consumer (packet controller, register file).

Parameters:
NUM_BITS, 8, data word width (>=2)
SHIFT_MSB, 0, 1 = shift toward MSB, serial_in enters bit 0; 0 = shift toward LSB, serial_in enters bit NUM_BITS-1
DEPTH, 2, output FIFO entries (>=1, any integer, not restricted to powers of 2)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush/restart
shift_enable  in  1  sample serial_in this cycle
serial_in  in  1  serial data bit
shift_out  out  NUM_BITS  live shift register contents
bit_count  out  $clog2(NUM_BITS+2)  bits received in current frame
word_out  out  NUM_BITS  FIFO head word
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts head
fifo_count  out  $clog2(DEPTH+1)  occupied entries
overrun  out  1  sticky: a completed word was dropped
parity_err  out  1  parity flag of head entry (see Optional Feature)

Behaviour:
- Reset (n_rst=0, async): shift_out all ones; bit_count=0; FIFO empty; word_valid=0; fifo_count=0; overrun=0; parity_err=0; word_out all ones.
- Shift: on a clk edge with shift_enable=1, shift_out moves one position per SHIFT_MSB and serial_in enters the vacated end. With shift_enable=0, shift_out holds.
- Frame: bit_count increments on each shift. A shift with bit_count==NUM_BITS-1 completes a word: the post-shift register value is pushed and bit_count wraps to 0. The shift register is not cleared between words.
- Latency: word_valid rises on the clock edge that performs the completing shift. word_out is valid in the following cycle.
- FIFO: word_out shows the oldest entry and is all ones when empty. word_valid = (fifo_count != 0).
- Pop: a pop occurs on any edge where word_valid=1 and word_ready=1.
- word_ready while empty: no effect.
- Push with FIFO not full: stored.
- Push with FIFO full and simultaneous pop: both happen; fifo_count unchanged; no overrun.
- Push with FIFO full and no pop: new word discarded; existing entries untouched; overrun set to 1. overrun stays set until clear or reset.
- Simultaneous push and pop, FIFO not full: fifo_count unchanged; order preserved.
- clear=1: on that edge, shift_out goes to all ones, bit_count to 0, FIFO flushed, overrun to 0, parity_err to 0. clear has priority over shift_enable, push and pop; bits sampled that cycle are lost.
- Reset mid-frame or mid-FIFO: all state returns to reset values immediately; partial word discarded.
- Width: bit_count and fifo_count are unsigned, sized by their $clog2 expressions; no wrap beyond the stated range.

Optional Feature:
FLEX_STP_PARITY_EN
- Defined: each frame is NUM_BITS data bits followed by one even-parity bit.
  - The parity-bit shift does not move shift_out.
  - bit_count runs 0..NUM_BITS; the word is pushed on the parity-bit edge.
  - Each FIFO entry carries a flag = (XOR of the word) XOR (parity bit). parity_err presents the head entry's flag, and is 0 when empty.
  - Overrun and clear rules apply unchanged to the flag.
- Not defined: frames are NUM_BITS bits; parity_err is tied to 0; no flag storage is synthesised.

Test Plan:
1. Reset: assert n_rst=0 mid-shift -> shift_out=0xFF, word_valid=0, fifo_count=0, overrun=0, bit_count=0 immediately (NUM_BITS=8).
2. SHIFT_MSB=0, word_ready=1, shift bits 1,0,1,0,0,1,0,1 back-to-back -> after 8th edge word_valid=1, word_out=0xA5, bit_count=0. Repeat with SHIFT_MSB=1 -> word_out=0xA5.
3. DEPTH=2, word_ready=0, send 0x11, 0x22, 0x33 -> fifo_count=2, overrun=1. Then word_ready=1 -> word_out=0x11, then 0x22, then word_valid=0; overrun stays 1.
4. FIFO full (0x11, 0x22), completing shift of 0x44 with word_ready=1 on the same edge -> 0x11 popped, FIFO holds 0x22, 0x44; fifo_count=2; overrun=0.
5. After 5 bits shifted, pulse clear with shift_enable=1 -> bit_count=0, shift_out=0xFF, FIFO empty, overrun=0. Next 8 bits of 0x3C yield word_out=0x3C.
6. With FLEX_STP_PARITY_EN: send 0xA5 + parity 0 -> parity_err=0. Send 0xA5 + parity 1 -> parity_err=1 while that entry is head. shift_out is unchanged by the parity-bit shift.

Source files
------------

// File: rtl/flex_stp_word_rx_if.sv
// Word-side bundle of flex_stp_word_rx: serial bit input plus the valid/ready word output.
// master = receiver, slave = consumer/front end.
interface flex_stp_word_rx_if #(
   parameter int NUM_BITS = 8
);
   logic                shift_enable;
   logic                serial_in;
   logic                word_ready;
   logic                word_valid;
   logic                parity_err;
   logic [NUM_BITS-1:0] word_out;

   modport master (
      input  shift_enable, serial_in, word_ready,
      output word_out, word_valid, parity_err
   );

   modport slave (
      output shift_enable, serial_in, word_ready,
      input  word_out, word_valid, parity_err
   );
endinterface

// File: rtl/flex_stp_word_rx.sv
// Serial-to-parallel word receiver with a DEPTH-entry output FIFO and sticky overrun.
// Optional trailing even-parity bit per frame when FLEX_STP_PARITY_EN is defined.
module flex_stp_word_rx #(
   parameter int NUM_BITS  = 8,
   parameter int SHIFT_MSB = 0,
   parameter int DEPTH     = 2
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            clear,
   output logic [NUM_BITS-1:0]             shift_out,
   output logic [$clog2(NUM_BITS+2)-1:0]   bit_count,
   output logic [$clog2(DEPTH+1)-1:0]      fifo_count,
   output logic                            overrun,
   flex_stp_word_rx_if.master              bus
);
   localparam int CW = $clog2(NUM_BITS+2);
   localparam int FW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FLEX_STP_PARITY_EN
   localparam int LAST = NUM_BITS;
`else
   localparam int LAST = NUM_BITS - 1;
`endif

   function automatic logic even_parity_f(input logic [NUM_BITS-1:0] w);
      return ^w;
   endfunction

   function automatic logic [PW-1:0] next_ptr_f(input logic [PW-1:0] p);
      if (int'(p) == DEPTH - 1) begin
         return {PW{1'b0}};
      end else begin
         return p + {{(PW-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [NUM_BITS-1:0] mem_r [DEPTH];
   logic [PW-1:0]       rd_ptr_r;
   logic [PW-1:0]       wr_ptr_r;
   logic [NUM_BITS-1:0] shift_next_s;
   logic [NUM_BITS-1:0] shift_adv_s;
   logic [NUM_BITS-1:0] push_word_s;
   logic                last_bit_s;
   logic                pop_s;
   logic                full_s;
   logic                wr_en_s;
   logic                drop_s;
`ifdef FLEX_STP_PARITY_EN
   logic                flag_r [DEPTH];
   logic                push_flag_s;
`endif

   // Next shift-register value, framing and FIFO handshake decode
   always_comb begin
      if (SHIFT_MSB != 0) begin
         shift_next_s = {shift_out[NUM_BITS-2:0], bus.serial_in};
      end else begin
         shift_next_s = {bus.serial_in, shift_out[NUM_BITS-1:1]};
      end
      last_bit_s = bus.shift_enable && (bit_count == LAST[CW-1:0]);
`ifdef FLEX_STP_PARITY_EN
      // The parity bit is consumed without disturbing the data word
      shift_adv_s = last_bit_s ? shift_out : shift_next_s;
      push_word_s = shift_out;
      push_flag_s = even_parity_f(shift_out) ^ bus.serial_in;
`else
      shift_adv_s = shift_next_s;
      push_word_s = shift_next_s;
`endif
      pop_s   = (fifo_count != {FW{1'b0}}) && bus.word_ready;
      full_s  = (fifo_count == DEPTH[FW-1:0]);
      wr_en_s = last_bit_s && (!full_s || pop_s);
      drop_s  = last_bit_s && full_s && !pop_s;
   end

   // Shift register and bit counter
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shift_out <= {NUM_BITS{1'b1}};
         bit_count <= {CW{1'b0}};
      end else if (clear) begin
         shift_out <= {NUM_BITS{1'b1}};
         bit_count <= {CW{1'b0}};
      end else if (bus.shift_enable) begin
         shift_out <= shift_adv_s;
         bit_count <= last_bit_s ? {CW{1'b0}} : bit_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         shift_out <= shift_out;
         bit_count <= bit_count;
      end
   end

   // Output FIFO storage, pointers, occupancy and sticky overrun
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {NUM_BITS{1'b1}};
`ifdef FLEX_STP_PARITY_EN
            flag_r[i] <= 1'b0;
`endif
         end
         rd_ptr_r   <= {PW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         fifo_count <= {FW{1'b0}};
         overrun    <= 1'b0;
      end else if (clear) begin
         rd_ptr_r   <= {PW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         fifo_count <= {FW{1'b0}};
         overrun    <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
`ifdef FLEX_STP_PARITY_EN
            flag_r[wr_ptr_r] <= push_flag_s;
`endif
            wr_ptr_r <= next_ptr_f(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr_f(rd_ptr_r);
         end
         case ({wr_en_s, pop_s})
            2'b10:   fifo_count <= fifo_count + {{(FW-1){1'b0}}, 1'b1};
            2'b01:   fifo_count <= fifo_count - {{(FW-1){1'b0}}, 1'b1};
            default: fifo_count <= fifo_count;
         endcase
         overrun <= overrun | drop_s;
      end
   end

   // Head presentation; empty FIFO shows all ones and no parity error
   always_comb begin
      bus.word_valid = (fifo_count != {FW{1'b0}});
      if (bus.word_valid) begin
         bus.word_out = mem_r[rd_ptr_r];
`ifdef FLEX_STP_PARITY_EN
         bus.parity_err = flag_r[rd_ptr_r];
`else
         bus.parity_err = 1'b0;
`endif
      end else begin
         bus.word_out   = {NUM_BITS{1'b1}};
         bus.parity_err = 1'b0;
      end
   end
endmodule

// File: tb/tb_flex_stp_word_rx.sv
// Bench for flex_stp_word_rx: two instances (SHIFT_MSB=0/1) checked every cycle against
// a queue-based model, plus hand-computed literal expectations.
module tb_flex_stp_word_rx;
   localparam int NB = 8;
   localparam int DP = 2;
`ifdef FLEX_STP_PARITY_EN
   localparam int FL = NB + 1;
`else
   localparam int FL = NB;
`endif

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic clear = 1'b0;
   logic se = 1'b0;
   logic si = 1'b0;
   logic rdy = 1'b0;

   always #5 clk = ~clk;

   flex_stp_word_rx_if #(.NUM_BITS(NB)) bus0 ();
   flex_stp_word_rx_if #(.NUM_BITS(NB)) bus1 ();
   assign bus0.shift_enable = se;
   assign bus0.serial_in    = si;
   assign bus0.word_ready   = rdy;
   assign bus1.shift_enable = se;
   assign bus1.serial_in    = si;
   assign bus1.word_ready   = rdy;

   logic [7:0] so0, so1;
   logic [3:0] bc0, bc1;
   logic [1:0] fc0, fc1;
   logic       ov0, ov1;

   flex_stp_word_rx #(.NUM_BITS(NB), .SHIFT_MSB(0), .DEPTH(DP)) u0 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_out(so0), .bit_count(bc0),
      .fifo_count(fc0), .overrun(ov0), .bus(bus0));
   flex_stp_word_rx #(.NUM_BITS(NB), .SHIFT_MSB(1), .DEPTH(DP)) u1 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_out(so1), .bit_count(bc1),
      .fifo_count(fc1), .overrun(ov1), .bus(bus1));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: last NB received bits (oldest first), one word queue per bit order, flags.
   bit         hist[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         fq[$];
   int         m_cnt;
   bit         m_ovr;

   function automatic void m_reset();
      hist = {};
      for (int i = 0; i < NB; i++) hist.push_back(1'b1);
      q0 = {}; q1 = {}; fq = {};
      m_cnt = 0;
      m_ovr = 1'b0;
   endfunction

   // SHIFT_MSB=0: oldest bit sits at bit 0; SHIFT_MSB=1: newest bit sits at bit 0
   function automatic logic [7:0] sr(input int msb);
      logic [7:0] r;
      for (int i = 0; i < NB; i++) r[i] = msb ? hist[NB-1-i] : hist[i];
      return r;
   endfunction

   function automatic void m_step();
      bit         pop, full, push, f;
      logic [7:0] w0, w1;
      if (!n_rst || clear) begin
         m_reset();
         return;
      end
      pop  = (q0.size() != 0) && rdy;
      full = (q0.size() == DP);
      push = 1'b0; f = 1'b0; w0 = 8'h00; w1 = 8'h00;
      if (se) begin
         if (FL == NB + 1 && m_cnt == NB) begin
            push = 1'b1; w0 = sr(0); w1 = sr(1); f = (^w0) ^ si; m_cnt = 0;
         end else begin
            hist.push_back(si);
            void'(hist.pop_front());
            m_cnt++;
            if (FL == NB && m_cnt == NB) begin
               push = 1'b1; w0 = sr(0); w1 = sr(1); m_cnt = 0;
            end
         end
      end
      if (pop) begin
         void'(q0.pop_front()); void'(q1.pop_front()); void'(fq.pop_front());
      end
      if (push) begin
         if (!full || pop) begin
            q0.push_back(w0); q1.push_back(w1); fq.push_back(f);
         end else begin
            m_ovr = 1'b1;
         end
      end
   endfunction

   task automatic cmp_inst(input int k, input logic [7:0] so, input logic [3:0] bc,
                           input logic [7:0] wo, input logic wv, input logic [1:0] fc,
                           input logic ov, input logic pe);
      logic [7:0] ew;
      ew = (k == 0) ? ((q0.size() != 0) ? q0[0] : 8'hFF) : ((q1.size() != 0) ? q1[0] : 8'hFF);
      chk($sformatf("shift_out%0d", k), so, sr(k));
      chk($sformatf("bit_count%0d", k), bc, m_cnt);
      chk($sformatf("word_out%0d", k), wo, ew);
      chk($sformatf("word_valid%0d", k), wv, q0.size() != 0);
      chk($sformatf("fifo_count%0d", k), fc, q0.size());
      chk($sformatf("overrun%0d", k), ov, m_ovr);
      chk($sformatf("parity_err%0d", k), pe, (fq.size() != 0) ? fq[0] : 1'b0);
   endtask

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      cmp_inst(0, so0, bc0, bus0.word_out, bus0.word_valid, fc0, ov0, bus0.parity_err);
      cmp_inst(1, so1, bc1, bus1.word_out, bus1.word_valid, fc1, ov1, bus1.parity_err);
   end

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   // Data bits LSB first, then the parity bit when framing includes one
   task automatic send_word(input logic [7:0] w, input logic p, input logic rdy_last);
      for (int i = 0; i < NB; i++) begin
         if (i == NB - 1 && FL == NB) rdy = rdy_last;
         se = 1'b1; si = w[i];
         tick();
      end
      if (FL == NB + 1) begin
         rdy = rdy_last; si = p;
         tick();
      end
      se = 1'b0;
   endtask

   initial begin
      logic [7:0] tbl [4];
      tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h81; tbl[3] = 8'h6B;
      m_reset();
      tick(); tick();
      n_rst = 1'b1;

      // 1: async reset in the middle of a frame
      se = 1'b1; si = 1'b0;
      tick(); tick(); tick();
      se = 1'b0;
      n_rst = 1'b0;
      m_reset();
      #1;
      chk("rst_shift_out", so0, 8'hFF);
      chk("rst_word_valid", bus0.word_valid, 1'b0);
      chk("rst_fifo_count", fc0, 2'd0);
      chk("rst_overrun", ov0, 1'b0);
      chk("rst_bit_count", bc0, 4'd0);
      tick();
      n_rst = 1'b1;
      tick();

      // 2: bits 1,0,1,0,0,1,0,1 give 0xA5 for both shift directions
      rdy = 1'b1;
      send_word(8'hA5, 1'b0, 1'b1);
      chk("t2_word_valid", bus0.word_valid, 1'b1);
      chk("t2_word_out_lsb", bus0.word_out, 8'hA5);
      chk("t2_word_out_msb", bus1.word_out, 8'hA5);
      chk("t2_bit_count", bc0, 4'd0);
      tick();
      rdy = 1'b0;

      // 3: fill, overflow, drain
      send_word(8'h11, ^8'h11, 1'b0);
      send_word(8'h22, ^8'h22, 1'b0);
      send_word(8'h33, ^8'h33, 1'b0);
      chk("t3_fifo_count", fc0, 2'd2);
      chk("t3_overrun", ov0, 1'b1);
      chk("t3_head0", bus0.word_out, 8'h11);
      rdy = 1'b1;
      tick();
      chk("t3_head1", bus0.word_out, 8'h22);
      tick();
      chk("t3_empty", bus0.word_valid, 1'b0);
      chk("t3_overrun_sticky", ov0, 1'b1);
      rdy = 1'b0;

      // 4: push into a full FIFO while popping
      clear = 1'b1; tick(); clear = 1'b0;
      send_word(8'h11, ^8'h11, 1'b0);
      send_word(8'h22, ^8'h22, 1'b0);
      send_word(8'h44, ^8'h44, 1'b1);
      chk("t4_fifo_count", fc0, 2'd2);
      chk("t4_head", bus0.word_out, 8'h22);
      chk("t4_overrun", ov0, 1'b0);
      tick();
      chk("t4_head_next", bus0.word_out, 8'h44);
      tick();
      rdy = 1'b0;

      // 5: clear mid-frame with shift_enable high, over a full FIFO with overrun
      send_word(8'h55, ^8'h55, 1'b0);
      send_word(8'h66, ^8'h66, 1'b0);
      send_word(8'h77, ^8'h77, 1'b0);
      se = 1'b1;
      for (int i = 0; i < 5; i++) begin
         si = i[0];
         tick();
      end
      clear = 1'b1; si = 1'b0;
      tick();
      clear = 1'b0; se = 1'b0;
      chk("t5_bit_count", bc0, 4'd0);
      chk("t5_shift_out", so0, 8'hFF);
      chk("t5_empty", bus0.word_valid, 1'b0);
      chk("t5_overrun", ov0, 1'b0);
      send_word(8'h3C, ^8'h3C, 1'b0);
      chk("t5_word_out", bus0.word_out, 8'h3C);
      rdy = 1'b1; tick(); rdy = 1'b0;

      // Extra patterns with alternating back-pressure, checked by the model
      for (int i = 0; i < 4; i++) begin
         send_word(tbl[i], ^tbl[i], i[0]);
         tick();
      end
      rdy = 1'b1; tick(); tick(); rdy = 1'b0;

`ifdef FLEX_STP_PARITY_EN
      // 6: good and bad parity
      clear = 1'b1; tick(); clear = 1'b0;
      send_word(8'hA5, 1'b0, 1'b0);
      chk("t6_perr_good", bus0.parity_err, 1'b0);
      chk("t6_shift_hold", so0, 8'hA5);
      send_word(8'hA5, 1'b1, 1'b0);
      chk("t6_shift_hold2", so0, 8'hA5);
      rdy = 1'b1;
      tick();
      chk("t6_perr_bad", bus0.parity_err, 1'b1);
      chk("t6_head", bus0.word_out, 8'hA5);
      tick();
      rdy = 1'b0;
      chk("t6_perr_empty", bus0.parity_err, 1'b0);
`endif

      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
